// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the mod-N counter.
// Direction/mode literals plus a load clamp function.
package counter_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  function automatic logic [31:0] clamp(
    input logic [31:0] val,
    input logic [31:0] max
  );
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-state logic for the mod-N counter.
// Wraps by explicit compare against MAX_VAL, never by overflow.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 6,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] cur_val,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_val,
  output logic             wrap_evt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic at_max;
  logic at_zero;
  logic is_up;
  logic is_wrap;
  logic cnt;

  assign at_max  = (cur_val == MAX_VAL);
  assign at_zero = (cur_val == '0);
  assign is_up   = (up == CNT_UP);
  assign is_wrap = (sat_mode == CNT_WRAP);
  assign cnt     = en & ~load;

  // Select load, step, boundary wrap, or hold
  always_comb begin
    next_val = cur_val;
    wrap_evt = 1'b0;
    unique case (1'b1)
      load: begin
        next_val = WIDTH'(clamp(32'(load_val),
                                32'(MAX_VAL)));
      end
      cnt & is_up & ~at_max: begin
        next_val = cur_val + ONE;
      end
      cnt & ~is_up & ~at_zero: begin
        next_val = cur_val - ONE;
      end
      cnt & is_up & at_max & is_wrap: begin
        next_val = '0;
        wrap_evt = 1'b1;
      end
      cnt & ~is_up & at_zero & is_wrap: begin
        next_val = MAX_VAL;
        wrap_evt = 1'b1;
      end
      default: begin
        next_val = cur_val;
        wrap_evt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mod_n_counter.sv
// Synchronous up/down mod-N counter with load, saturate and wrap status.
// Optional sticky overflow flag: MOD_N_COUNTER_OVF_STICKY_EN.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 6,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] cur_val,
  output logic             tc,
  output logic             wrapped,
  output logic             at_limit
);

  logic [WIDTH-1:0] cur_val_q;
  logic [WIDTH-1:0] cur_val_d;
  logic             wrapped_q;
  logic             wrapped_d;
  logic [WIDTH-1:0] next_val;
  logic             wrap_evt;
  logic             at_max;
  logic             at_zero;

  counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .cur_val  (cur_val_q),
    .up       (up),
    .sat_mode (sat_mode),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .next_val (next_val),
    .wrap_evt (wrap_evt)
  );

  assign at_max  = (cur_val_q == MAX_VAL);
  assign at_zero = (cur_val_q == '0);

  assign tc = en & ~load &
              (((up == CNT_UP) & at_max) |
               ((up == CNT_DOWN) & at_zero));
  assign at_limit = at_max | at_zero;
  assign cur_val  = cur_val_q;
  assign wrapped  = wrapped_q;

  // Reset overrides the next-state logic
  always_comb begin
    cur_val_d = next_val;
    wrapped_d = wrap_evt;
    if (!reset) begin
      cur_val_d = RESET_VAL;
      wrapped_d = 1'b0;
    end
  end

  // Count and wrap-pulse registers
  always_ff @(posedge clk) begin
    cur_val_q <= cur_val_d;
    wrapped_q <= wrapped_d;
  end

`ifdef MOD_N_COUNTER_OVF_STICKY_EN
  logic ovf_sticky_q;
  logic ovf_sticky_d;

  assign ovf_sticky = ovf_sticky_q;

  // Sticky flag: set on tc beats a same-cycle clear
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (ovf_clr) ovf_sticky_d = 1'b0;
    if (tc)      ovf_sticky_d = 1'b1;
    if (!reset)  ovf_sticky_d = 1'b0;
  end

  // Sticky overflow register
  always_ff @(posedge clk) begin
    ovf_sticky_q <= ovf_sticky_d;
  end
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: 6-bit full range and 4-bit MAX_VAL=9 instances.
// Directed table, corner sequences, then random run vs reference model.
module tb_mod_n_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       sat_mode;
  logic       load;
  logic [5:0] load_val;
  logic [5:0] cur_a;
  logic [3:0] cur_b;
  logic       tc_a, tc_b;
  logic       wr_a, wr_b;
  logic       al_a, al_b;
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
  logic       ovf_clr;
  logic       ovf_a, ovf_b;
`endif

  int vectors;
  int miscompares;

  mod_n_counter u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .sat_mode   (sat_mode),
    .load       (load),
    .load_val   (load_val),
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_a),
`endif
    .cur_val    (cur_a),
    .tc         (tc_a),
    .wrapped    (wr_a),
    .at_limit   (al_a)
  );

  mod_n_counter #(
    .WIDTH     (4),
    .MAX_VAL   (4'd9),
    .RESET_VAL (4'd0)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .sat_mode   (sat_mode),
    .load       (load),
    .load_val   (load_val[3:0]),
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_b),
`endif
    .cur_val    (cur_b),
    .tc         (tc_b),
    .wrapped    (wr_b),
    .at_limit   (al_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = 6-bit/63, 1 = 4-bit/9
  int mx[2] = '{63, 9};
  int mc[2];
  int mw[2];
  int mo[2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit m_tc(input int k, input bit e,
                              input bit u, input bit l);
    return e && !l &&
           ((u && mc[k] == mx[k]) || (!u && mc[k] == 0));
  endfunction

  // One clock: drive, check combinational, edge, check registers
  task automatic cyc(input bit r, input bit e, input bit u,
                     input bit s, input bit l,
                     input logic [5:0] lv, input bit clr);
    bit tk[2];
    int lvk;
    reset = r; en = e; up = u; sat_mode = s;
    load = l; load_val = lv;
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
    ovf_clr = clr;
`endif
    #1;
    for (int k = 0; k < 2; k++) tk[k] = m_tc(k, e, u, l);
    chk("tc_a", 32'(tc_a), 32'(tk[0]));
    chk("tc_b", 32'(tc_b), 32'(tk[1]));
    chk("at_limit_a", 32'(al_a),
        32'(mc[0] == 0 || mc[0] == mx[0]));
    chk("at_limit_b", 32'(al_b),
        32'(mc[1] == 0 || mc[1] == mx[1]));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      lvk = (k == 0) ? int'(lv) : int'(lv) % 16;
      if (!r) begin
        mc[k] = 0; mw[k] = 0; mo[k] = 0;
      end else begin
        if (tk[k]) mo[k] = 1;
        else if (clr) mo[k] = 0;
        if (l) begin
          mc[k] = (lvk > mx[k]) ? mx[k] : lvk;
          mw[k] = 0;
        end else if (e && tk[k]) begin
          mw[k] = s ? 0 : 1;
          if (!s) mc[k] = u ? 0 : mx[k];
        end else if (e) begin
          mc[k] = u ? mc[k] + 1 : mc[k] - 1;
          mw[k] = 0;
        end else begin
          mw[k] = 0;
        end
      end
    end
    #1;
    chk("cur_val_a", 32'(cur_a), 32'(mc[0]));
    chk("cur_val_b", 32'(cur_b), 32'(mc[1]));
    chk("wrapped_a", 32'(wr_a), 32'(mw[0]));
    chk("wrapped_b", 32'(wr_b), 32'(mw[1]));
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
    chk("ovf_a", 32'(ovf_a), 32'(mo[0]));
    chk("ovf_b", 32'(ovf_b), 32'(mo[1]));
`endif
    @(negedge clk);
  endtask

  typedef struct {
    bit r, e, u, s, l;
    logic [5:0] lv;
    int ea;
    int eb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    vectors = 0;
    miscompares = 0;
    mc = '{0, 0}; mw = '{0, 0}; mo = '{0, 0};
    reset = 1'b0; en = 1'b0; up = 1'b1; sat_mode = 1'b0;
    load = 1'b0; load_val = '0;
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif

    //          r  e  u  s  l  lv   A   B
    tbl[0]  = '{0, 0, 1, 0, 0, 0,   0,  0};
    tbl[1]  = '{1, 1, 1, 0, 1, 12, 12,  9};
    tbl[2]  = '{1, 1, 1, 0, 1, 4,   4,  4};
    tbl[3]  = '{1, 1, 1, 0, 0, 0,   5,  5};
    tbl[4]  = '{1, 1, 0, 0, 0, 0,   4,  4};
    tbl[5]  = '{1, 0, 1, 0, 1, 9,   9,  9};
    tbl[6]  = '{1, 1, 1, 0, 0, 0,  10,  0};
    tbl[7]  = '{1, 1, 1, 1, 0, 0,  11,  1};
    tbl[8]  = '{1, 0, 1, 0, 1, 63, 63,  9};
    tbl[9]  = '{1, 1, 1, 1, 0, 0,  63,  9};
    tbl[10] = '{1, 1, 1, 0, 0, 0,   0,  0};
    tbl[11] = '{1, 1, 0, 0, 0, 0,  63,  9};
    tbl[12] = '{1, 0, 0, 0, 0, 0,  63,  9};
    tbl[13] = '{0, 1, 1, 0, 1, 5,   0,  0};
    tbl[14] = '{1, 1, 0, 1, 0, 0,   0,  0};

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].s,
          tbl[i].l, tbl[i].lv, 1'b0);
      chk($sformatf("tbl%0d_a", i), 32'(cur_a), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_b", i), 32'(cur_b), 32'(tbl[i].eb));
    end

    // Full 6-bit up count 0..63 then wrap to 0
    cyc(0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      cyc(1, 1, 1, 0, 0, 0, 0);
      chk("seq_up_a", 32'(cur_a), 32'(i % 64));
      chk("seq_up_wr_a", 32'(wr_a), 32'(i == 64));
    end
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("seq_up_wr_drop", 32'(wr_a), 32'd0);

    // MAX_VAL=9 down from 0: 0 -> 9 -> 8
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("seq_dn_b9", 32'(cur_b), 32'd9);
    chk("seq_dn_wr_b", 32'(wr_b), 32'd1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("seq_dn_b8", 32'(cur_b), 32'd8);
    chk("seq_dn_wr_b0", 32'(wr_b), 32'd0);

    // Saturating up count stops at 9
    cyc(0, 0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      cyc(1, 1, 1, 1, 0, 0, 0);
      chk("seq_sat_b", 32'(cur_b), 32'(i > 9 ? 9 : i));
      chk("seq_sat_wr_b", 32'(wr_b), 32'd0);
    end

    // Sticky overflow: set, hold, set beats clear, clear alone
    cyc(1, 0, 1, 0, 1, 63, 1);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 0, 0);

    // Random run
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) != 0),
          ($urandom_range(0, 7) != 0),
          1'($urandom),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0),
          6'($urandom),
          ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised synchronous up/down counter; successor to the fixed 6-bit ripple counter used for processor timing and cycle counting. Fully synchronous: all bits update on the same clk edge, with no ripple clocking. Adds the following features:
- programmable modulus
- direction control
- parallel load
- count enable
- wrap or saturate mode
- terminal-count and wrap status

It is the standard counter for multi-cycle unit sequencing (multdiv cycle count, stall timers, ROB/queue pointers).

Parameters:
WIDTH, 6, counter width in bits (1..32)
MAX_VAL, 2**WIDTH-1, highest count value; the counter's range is 0..MAX_VAL; must be < 2**WIDTH
RESET_VAL, 0, value loaded on reset; must be <= MAX_VAL

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous reset, active-low; sampled on the rising edge of clk
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
sat_mode  input  1  1 = saturate at the range limits, 0 = wrap modulo MAX_VAL+1
load  input  1  parallel load strobe
load_val  input  WIDTH  value for the parallel load
cur_val  output  WIDTH  current count (registered)
tc  output  1  terminal count (combinational)
wrapped  output  1  one-cycle pulse (registered)
at_limit  output  1  range-limit flag (combinational)

Behaviour:
- Reset: reset=0 at a rising edge sets cur_val=RESET_VAL and wrapped=0. tc and at_limit follow from cur_val and the inputs.
- Priority per edge: reset, then load, then en; with none active, cur_val holds.
- Load:
  - cur_val <= load_val when load_val <= MAX_VAL; otherwise cur_val <= MAX_VAL (clamped).
  - Load overrides en; wrapped=0 on a load cycle.
- Count (en=1, load=0):
  - up=1, cur_val<MAX_VAL: cur_val+1.
  - up=0, cur_val>0: cur_val-1.
  - At a boundary (up=1 and cur_val==MAX_VAL, or up=0 and cur_val==0):
    - sat_mode=0: wrap to 0 (up) or to MAX_VAL (down); wrapped=1 on the next cycle.
    - sat_mode=1: hold the value; wrapped=0.
- tc = en & ~load & ((up & cur_val==MAX_VAL) | (~up & cur_val==0)). It asserts in the cycle before a wrap or saturation event.
- at_limit = (cur_val==MAX_VAL) | (cur_val==0). It is independent of en.
- wrapped is a registered single-cycle pulse. Back-to-back wraps (e.g. MAX_VAL=0, or WIDTH=1 counting continuously) keep wrapped high on every wrapping cycle.
- Arithmetic: modulo wrap uses an explicit compare against MAX_VAL, never natural 2**WIDTH overflow. Non-power-of-two MAX_VAL must therefore wrap correctly.
- Direction or mode changes take effect on the same edge they are sampled. There is no pipeline; latency from input to cur_val is 1 cycle.
- Reset asserted mid-count aborts the count; it has priority over a simultaneous load or en.
- Inputs sampled during reset=0 are ignored.

Optional Feature:
Macro: MOD_N_COUNTER_OVF_STICKY_EN
- Defined: adds two ports.
  - ovf_clr (input, 1): clears ovf_sticky.
  - ovf_sticky (output, 1): registered; set on any cycle where tc=1, whether the counter wraps or saturates.
  - Clear rules: cleared by reset=0 or by ovf_clr=1. When a set and ovf_clr occur in the same cycle, set wins.
- Undefined: both ports are absent; no extra flops are present.

Decomposition:
- Package counter_pkg:
  - CNT_DOWN=1'b0, CNT_UP=1'b1
  - CNT_WRAP=1'b0, CNT_SAT=1'b1
  - a helper function clamp(val, max)
- Sub-module counter_next (combinational):
  - takes cur_val, up, sat_mode, en, load, load_val
  - returns next_val and wrap_evt
- mod_n_counter holds only the registers and the status outputs.

Test Plan:
- WIDTH=6 default, reset=0 then released, en=1 up=1 sat_mode=0 for 64 cycles -> cur_val 0..63 then 0; tc=1 at 63; wrapped=1 exactly one cycle after 63->0.
- MAX_VAL=9, up=0 from 0, sat_mode=0 -> 0->9->8; tc=1 at 0; wrapped pulse once.
- MAX_VAL=9, sat_mode=1, up=1 for 15 cycles -> cur_val stops at 9 and holds; wrapped stays 0; tc=1 while at 9.
- load=1 load_val=12 with MAX_VAL=9 and en=1 in the same cycle -> cur_val=9, no count that cycle; then load_val=4 -> cur_val=4.
- Counting at cur_val=5, reset=0 together with load=1 -> cur_val=RESET_VAL (0) next cycle; wrapped=0.
- With MOD_N_COUNTER_OVF_STICKY_EN: wrap 63->0 -> ovf_sticky=1 and holds; ovf_clr=1 together with a new tc -> stays 1; ovf_clr alone -> 0.
